// File: rtl/dft_pkg.sv
// Shared definitions for the DFT result framer: sync byte default, framer
// state encoding and the frame length calculation.
package dft_pkg;

    // Sync byte that opens every frame
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Framer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } framer_state_t;

    // Bytes per frame: header + (re, im) per bin split into SPI words + checksum
    function automatic int frame_len(input int bin_num, input int dft_width, input int spi_width);
        return 2 + 2 * bin_num * (dft_width / spi_width);
    endfunction

endpackage

// File: rtl/dft_result_framer.sv
// Latches DFT bin results on the engine's done pulse and serialises them as
// header, payload (re then im per bin, MS word first) and XOR checksum into
// the SPI slave tx port, one word per ready/accept handshake.
module dft_result_framer
    import dft_pkg::*;
#(
    parameter int                   SPI_WIDTH = 8,
    parameter int                   DFT_WIDTH = 16,
    parameter int                   BIN_NUM   = 1,
    parameter logic [SPI_WIDTH-1:0] HEADER    = SPI_WIDTH'(HEADER_DEFAULT)
) (
    input  logic                        i_sys_clk,
    input  logic                        i_sys_rst,
    input  logic signed [DFT_WIDTH-1:0] i_X [BIN_NUM][2],
    input  logic                        i_done,
    input  logic                        i_tx_ready,
    output logic [SPI_WIDTH-1:0]        o_data,
    output logic                        o_wr,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic [15:0]                 o_frame_cnt
);

    localparam int BPW   = DFT_WIDTH / SPI_WIDTH;
    localparam int L     = frame_len(BIN_NUM, DFT_WIDTH, SPI_WIDTH);
    localparam int CNT_W = $clog2(L + 1);

    if ((DFT_WIDTH % SPI_WIDTH) != 0) begin : g_width_check
        $error("DFT_WIDTH must be an integer multiple of SPI_WIDTH");
    end

    framer_state_t               state, state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic [SPI_WIDTH-1:0]        cksum;
    logic [SPI_WIDTH-1:0]        byte_sel;
    logic signed [DFT_WIDTH-1:0] snap [BIN_NUM][2];
    logic                        start;
    logic                        load;
    logic                        ack;
    logic                        last;

    assign last   = (cnt == CNT_W'(L - 1));
    assign o_busy = (state != IDLE);

    // Next-state and handshake decode; o_wr only ever fires with the slave ready
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        load      = 1'b0;
        ack       = 1'b0;
        o_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (i_done) begin
                    start     = 1'b1;
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (i_tx_ready) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (i_tx_ready) begin
                    o_wr      = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!i_tx_ready) begin
                    ack       = 1'b1;
                    state_nxt = last ? IDLE : WAIT_RDY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte-select mux: header, payload word addressed by cnt, or checksum
    always_comb begin
        byte_sel = '0;
        if (cnt == '0) begin
            byte_sel = HEADER;
        end else if (last) begin
            byte_sel = cksum;
        end else begin
            for (int b = 0; b < BIN_NUM; b++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int k = 0; k < BPW; k++) begin
                        if (cnt == CNT_W'(1 + (b * 2 + c) * BPW + k))
                            byte_sel = snap[b][c][(BPW - 1 - k) * SPI_WIDTH +: SPI_WIDTH];
                    end
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Byte counter and running payload checksum
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            cnt   <= '0;
            cksum <= '0;
        end else begin
            if (start) begin
                cnt   <= '0;
                cksum <= '0;
            end else begin
                if (o_wr && (cnt != '0) && !last)
                    cksum <= cksum ^ o_data;
                if (ack)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    // Output word register, frame counter and sticky overrun flag
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            o_data      <= '0;
            o_frame_cnt <= '0;
            o_overrun   <= 1'b0;
        end else begin
            if (load)
                o_data <= byte_sel;
            if (ack && last)
                o_frame_cnt <= o_frame_cnt + 16'd1;
            if (i_done && (state != IDLE))
                o_overrun <= 1'b1;
        end
    end

    // Snapshot of all bin results, taken only when a frame starts
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            for (int b = 0; b < BIN_NUM; b++)
                for (int c = 0; c < 2; c++)
                    snap[b][c] <= '0;
        end else if (start) begin
            for (int b = 0; b < BIN_NUM; b++)
                for (int c = 0; c < 2; c++)
                    snap[b][c] <= i_X[b][c];
        end
    end

endmodule

// File: tb/tb_dft_result_framer.sv
// Directed bench for dft_result_framer: a one-bin instance and a two-bin
// instance share clock, reset and a model SPI slave.
module tb_dft_result_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: BIN_NUM=1
    logic signed [15:0] x_a [1][2];
    logic               done_a = 1'b0;
    logic               rdy_a;
    logic [7:0]         data_a;
    logic               wr_a, busy_a, ovr_a;
    logic [15:0]        fcnt_a;

    // Instance B: BIN_NUM=2
    logic signed [15:0] x_b [2][2];
    logic               done_b = 1'b0;
    logic               rdy_b;
    logic [7:0]         data_b;
    logic               wr_b, busy_b, ovr_b;
    logic [15:0]        fcnt_b;

    dft_result_framer #(.SPI_WIDTH(8), .DFT_WIDTH(16), .BIN_NUM(1)) dut_a (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_X(x_a), .i_done(done_a),
        .i_tx_ready(rdy_a), .o_data(data_a), .o_wr(wr_a), .o_busy(busy_a),
        .o_overrun(ovr_a), .o_frame_cnt(fcnt_a)
    );

    dft_result_framer #(.SPI_WIDTH(8), .DFT_WIDTH(16), .BIN_NUM(2)) dut_b (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_X(x_b), .i_done(done_b),
        .i_tx_ready(rdy_b), .o_data(data_b), .o_wr(wr_b), .o_busy(busy_b),
        .o_overrun(ovr_b), .o_frame_cnt(fcnt_b)
    );

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    logic [7:0] qa [$];
    logic [7:0] qb [$];

    // Model slave: ready drops the cycle after a write, returns two cycles later
    logic       rdy_m [2];
    logic       wr_seen [2];
    int         hold [2];
    logic       stall = 1'b0;
    assign rdy_a = rdy_m[0] & ~stall;
    assign rdy_b = rdy_m[1] & ~stall;

    // Byte capture and protocol watch, sampled mid-cycle
    initial begin
        wr_seen[0] = 1'b0;
        wr_seen[1] = 1'b0;
        forever begin
            @(negedge clk);
            wr_seen[0] = wr_a;
            wr_seen[1] = wr_b;
            if (wr_a) qa.push_back(data_a);
            if (wr_b) qb.push_back(data_b);
            if (wr_a && !rdy_a) viol++;
            if (wr_b && !rdy_b) viol++;
        end
    end

    // Slave ready model, updated just after each rising edge
    initial begin
        for (int i = 0; i < 2; i++) begin
            rdy_m[i] = 1'b1;
            hold[i]  = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    rdy_m[i] = 1'b1;
                    hold[i]  = 0;
                end else if (wr_seen[i]) begin
                    rdy_m[i] = 1'b0;
                    hold[i]  = 2;
                end else if (hold[i] > 0) begin
                    hold[i] = hold[i] - 1;
                    if (hold[i] == 0) rdy_m[i] = 1'b1;
                end
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic pulse_a();
        @(posedge clk); #1 done_a = 1'b1;
        @(posedge clk); #1 done_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(posedge clk); #1 done_b = 1'b1;
        @(posedge clk); #1 done_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!busy_a) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_idle_timeout busy=%0b exp=0", name, busy_a); end
    endtask

    task automatic wait_idle_b(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!busy_b) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_idle_timeout busy=%0b exp=0", name, busy_b); end
    endtask

    task automatic wait_qa(input int n, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (qa.size() >= n) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL %s_byte_timeout got=%0d exp=%0d", name, qa.size(), n); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wr_a !== 1'b0)    begin failures++; $display("FAIL reset_wr got=%0b exp=0", wr_a); end
        checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", data_a); end
        checks++; if (ovr_a !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%0b exp=0", ovr_a); end
        checks++; if (fcnt_a !== 16'd0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", fcnt_a); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_b !== 1'b0)  begin failures++; $display("FAIL reset_busy_b got=%0b exp=0", busy_b); end
        checks++; if (qa.size() != 0)   begin failures++; $display("FAIL reset_no_write got=%0d exp=0", qa.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [6] = '{8'hA5, 8'h12, 8'h34, 8'hFF, 8'h80, 8'h59};
        logic [7:0] got;
        int lat = 0;
        qa.delete();
        x_a[0][0] = 16'h1234;
        x_a[0][1] = 16'hFF80;
        pulse_a();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL basic_busy_after_done got=%0b exp=1", busy_a); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (wr_a) break;
        end
        checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        wait_idle_a("basic");
        checks++; if (qa.size() != 6) begin failures++; $display("FAIL basic_len got=%0d exp=6", qa.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
        checks++; if (fcnt_a !== 16'd1) begin failures++; $display("FAIL basic_fcnt got=%0d exp=1", fcnt_a); end
        checks++; if (ovr_a !== 1'b0)   begin failures++; $display("FAIL basic_overrun got=%0b exp=0", ovr_a); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [6] = '{8'hA5, 8'h12, 8'h34, 8'hFF, 8'h80, 8'h59};
        logic [7:0] got;
        int wr_during = 0;
        qa.delete();
        pulse_a();
        wait_qa(2, "bp");
        @(posedge clk); #1 stall = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wr_a) wr_during++;
        end
        checks++; if (wr_during != 0) begin failures++; $display("FAIL bp_wr_in_stall got=%0d exp=0", wr_during); end
        checks++; if (qa.size() != 2) begin failures++; $display("FAIL bp_bytes_in_stall got=%0d exp=2", qa.size()); end
        @(posedge clk); #1 stall = 1'b0;
        wait_idle_a("bp");
        checks++; if (qa.size() != 6) begin failures++; $display("FAIL bp_len got=%0d exp=6", qa.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL bp_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
        checks++; if (fcnt_a !== 16'd2) begin failures++; $display("FAIL bp_fcnt got=%0d exp=2", fcnt_a); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [6] = '{8'hA5, 8'h12, 8'h34, 8'hFF, 8'h80, 8'h59};
        logic [7:0] got;
        qa.delete();
        pulse_a();
        wait_qa(3, "ovr");
        x_a[0][0] = 16'hDEAD;
        x_a[0][1] = 16'hBEEF;
        pulse_a();
        checks++; if (ovr_a !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", ovr_a); end
        wait_idle_a("ovr");
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (qa.size() != 6) begin failures++; $display("FAIL ovr_len got=%0d exp=6", qa.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL ovr_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
        checks++; if (fcnt_a !== 16'd3) begin failures++; $display("FAIL ovr_fcnt got=%0d exp=3", fcnt_a); end
        checks++; if (ovr_a !== 1'b1)   begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", ovr_a); end
    endtask

    task automatic test_two_bins();
        logic [7:0] exp [10] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h02,
                                 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h03};
        logic [7:0] got;
        qb.delete();
        x_b[0][0] = 16'h0001;
        x_b[0][1] = 16'h0002;
        x_b[1][0] = 16'h8000;
        x_b[1][1] = 16'h7FFF;
        pulse_b();
        wait_idle_b("bin2");
        checks++; if (qb.size() != 10) begin failures++; $display("FAIL bin2_len got=%0d exp=10", qb.size()); end
        for (int i = 0; i < 10; i++) begin
            got = (i < qb.size()) ? qb[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL bin2_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
        checks++; if (fcnt_b !== 16'd1) begin failures++; $display("FAIL bin2_fcnt got=%0d exp=1", fcnt_b); end
        checks++; if (ovr_b !== 1'b0)   begin failures++; $display("FAIL bin2_overrun got=%0b exp=0", ovr_b); end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp [6] = '{8'hA5, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h81};
        logic [7:0] got;
        qa.delete();
        x_a[0][0] = 16'h1234;
        x_a[0][1] = 16'hFF80;
        pulse_a();
        wait_qa(3, "arst");
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0)   begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy_a); end
        checks++; if (wr_a !== 1'b0)     begin failures++; $display("FAIL arst_wr got=%0b exp=0", wr_a); end
        checks++; if (data_a !== 8'h00)  begin failures++; $display("FAIL arst_data got=%02h exp=00", data_a); end
        checks++; if (fcnt_a !== 16'd0)  begin failures++; $display("FAIL arst_fcnt got=%0d exp=0", fcnt_a); end
        checks++; if (ovr_a !== 1'b0)    begin failures++; $display("FAIL arst_overrun got=%0b exp=0", ovr_a); end
        checks++; if (fcnt_b !== 16'd0)  begin failures++; $display("FAIL arst_fcnt_b got=%0d exp=0", fcnt_b); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        qa.delete();
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++; if (qa.size() != 0) begin failures++; $display("FAIL arst_no_write got=%0d exp=0", qa.size()); end
        x_a[0][0] = 16'h7FFF;
        x_a[0][1] = 16'h0001;
        pulse_a();
        wait_idle_a("arst");
        checks++; if (qa.size() != 6) begin failures++; $display("FAIL arst_len got=%0d exp=6", qa.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL arst_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
        checks++; if (fcnt_a !== 16'd1) begin failures++; $display("FAIL arst_fcnt_after got=%0d exp=1", fcnt_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [12] = '{8'hA5, 8'h12, 8'h34, 8'hFF, 8'h80, 8'h59,
                                 8'hA5, 8'h80, 8'h00, 8'h00, 8'h10, 8'h90};
        logic [7:0] got;
        qa.delete();
        x_a[0][0] = 16'h1234;
        x_a[0][1] = 16'hFF80;
        pulse_a();
        x_a[0][0] = 16'h8000;
        x_a[0][1] = 16'h0010;
        wait_idle_a("b2b_first");
        pulse_a();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL b2b_accepted got=%0b exp=1", busy_a); end
        wait_idle_a("b2b_second");
        checks++; if (ovr_a !== 1'b0)   begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", ovr_a); end
        checks++; if (fcnt_a !== 16'd3) begin failures++; $display("FAIL b2b_fcnt got=%0d exp=3", fcnt_a); end
        checks++; if (qa.size() != 12) begin failures++; $display("FAIL b2b_len got=%0d exp=12", qa.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i < qa.size()) ? qa[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d got=%02h exp=%02h", i, got, exp[i]); end
        end
    endtask

    task automatic test_protocol();
        checks++; if (viol != 0) begin failures++; $display("FAIL wr_while_not_ready got=%0d exp=0", viol); end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            x_a[0][c] = '0;
            x_b[0][c] = '0;
            x_b[1][c] = '0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_two_bins();
        test_async_reset();
        test_back_to_back();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
